// File: rtl/systolic_tile_sequencer.sv
// Sequences one matrix-tile job through a ROWS x COLS systolic array:
// skewed operand feed, pipeline drain, then handshaked result-row readout.
module systolic_tile_sequencer #(
   parameter int ROWS = 2,
   parameter int COLS = 2,
   parameter int KW   = 8
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic [KW-1:0]                               k_len,
   input  logic                                        abort,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        acc_clr,
   output logic                                        feed_en,
   output logic [KW-1:0]                               feed_addr,
   output logic [ROWS-1:0]                             row_en,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]  out_row
);

   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DRAIN = ROWS + COLS - 1;
   localparam int DW    = $clog2(DRAIN + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_WRITE, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [KW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic [RW-1:0]   row_q, row_d;

   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            acc_clr_q, acc_clr_d;
   logic            feed_en_q, feed_en_d;
   logic [KW-1:0]   feed_addr_q, feed_addr_d;
   logic [ROWS-1:0] row_en_q, row_en_d;
   logic            out_valid_q, out_valid_d;
   logic [RW-1:0]   out_row_q, out_row_d;

   logic            flush;

   assign flush = abort && (state_q != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         addr_q      <= '0;
         drain_q     <= '0;
         row_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         acc_clr_q   <= 1'b0;
         feed_en_q   <= 1'b0;
         feed_addr_q <= '0;
         row_en_q    <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         addr_q      <= addr_d;
         drain_q     <= drain_d;
         row_q       <= row_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         acc_clr_q   <= acc_clr_d;
         feed_en_q   <= feed_en_d;
         feed_addr_q <= feed_addr_d;
         row_en_q    <= row_en_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      addr_d  = addr_q;
      drain_d = drain_q;
      row_d   = row_q;
      if (flush) begin
         state_d = S_IDLE;
         addr_d  = '0;
         drain_d = '0;
         row_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  if (k_len != '0) begin
                     state_d = S_LOAD;
                     k_d     = k_len;
                     addr_d  = '0;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_LOAD: begin
               // Compare against k-1 so k = 2^KW-1 finishes without the index wrapping.
               if (addr_q == k_q - KW'(1)) begin
                  state_d = S_DRAIN;
                  drain_d = '0;
               end else begin
                  addr_d = addr_q + KW'(1);
               end
            end
            S_DRAIN: begin
               if (drain_q == DW'(DRAIN - 1)) begin
                  state_d = S_WRITE;
                  row_d   = '0;
               end else begin
                  drain_d = drain_q + DW'(1);
               end
            end
            S_WRITE: begin
               if (out_ready) begin
                  if (row_q == RW'(ROWS - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from next state so they appear registered in the cycle they describe.
   always_comb begin
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      feed_en_d   = (state_d == S_LOAD);
      acc_clr_d   = feed_en_d && (addr_d == '0);
      feed_addr_d = feed_en_d ? addr_d : '0;
      out_valid_d = (state_d == S_WRITE);
      out_row_d   = out_valid_d ? row_d : '0;
      row_en_d    = '0;
      if (!flush) begin
         row_en_d[0] = feed_en_d;
         for (int r = 1; r < ROWS; r++) begin
            row_en_d[r] = row_en_q[r-1];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign acc_clr   = acc_clr_q;
   assign feed_en   = feed_en_q;
   assign feed_addr = feed_addr_q;
   assign row_en    = row_en_q;
   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench for systolic_tile_sequencer (ROWS=COLS=2, KW=4): directed jobs push
// expected feed/row/done events; a monitor pops and compares as the DUT presents them.
module tb_systolic_tile_sequencer;

   localparam int ROWS = 2;
   localparam int COLS = 2;
   localparam int KW   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            abort;
   logic            busy;
   logic            done;
   logic            acc_clr;
   logic            feed_en;
   logic [KW-1:0]   feed_addr;
   logic [ROWS-1:0] row_en;
   logic            out_valid;
   logic            out_ready;
   logic [0:0]      out_row;

   typedef struct { int c; int addr; int clr; } feed_t;
   typedef struct { int c; int row; } row_t;

   feed_t feed_q[$];
   row_t  row_q[$];
   int    done_q[$];
   feed_t fe;
   row_t  re;
   int    de;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   systolic_tile_sequencer #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .acc_clr   (acc_clr),
      .feed_en   (feed_en),
      .feed_addr (feed_addr),
      .row_en    (row_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_done"},      done,      0);
      check({tag, "_feed_en"},   feed_en,   0);
      check({tag, "_acc_clr"},   acc_clr,   0);
      check({tag, "_feed_addr"}, feed_addr, 0);
      check({tag, "_row_en"},    row_en,    0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_row"},   out_row,   0);
   endtask

   task automatic push_feed(input int t, input int n);
      for (int i = 0; i < n; i++) feed_q.push_back('{c: t + 1 + i, addr: i, clr: int'(i == 0)});
   endtask

   task automatic push_row(input int c, input int r);
      row_q.push_back('{c: c, row: r});
   endtask

   task automatic push_k3_job(input int t);
      push_feed(t, 3);
      push_row(t + 7, 0);
      push_row(t + 8, 1);
      done_q.push_back(t + 9);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_feed_left"}, feed_q.size(), 0);
      check({tag, "_row_left"},  row_q.size(),  0);
      check({tag, "_done_left"}, done_q.size(), 0);
   endtask

   // Monitor: sample after inputs driven on the falling edge have settled.
   always @(negedge clk) begin
      #1;
      if (feed_en === 1'b1) begin
         check("feed_expected", feed_q.size() > 0, 1);
         if (feed_q.size() > 0) begin
            fe = feed_q.pop_front();
            check("feed_cycle", cyc, fe.c);
            check("feed_addr", feed_addr, fe.addr);
            check("acc_clr", acc_clr, fe.clr);
         end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         check("row_expected", row_q.size() > 0, 1);
         if (row_q.size() > 0) begin
            re = row_q.pop_front();
            check("row_cycle", cyc, re.c);
            check("out_row", out_row, re.row);
         end
      end
      if (done === 1'b1) begin
         check("done_expected", done_q.size() > 0, 1);
         if (done_q.size() > 0) begin
            de = done_q.pop_front();
            check("done_cycle", cyc, de);
         end
      end
   end

   initial begin
      int t;
      int re_tab[11];
      re_tab = '{0, 1, 3, 3, 2, 0, 0, 0, 0, 0, 0};
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; k_len = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      // Basic k=3 job with out_ready high.
      t = cyc; start = 1'b1; k_len = 4'd3;
      push_k3_job(t);
      for (int i = 0; i <= 10; i++) begin
         check("t1_row_en", row_en, re_tab[i]);
         check("t1_busy", busy, int'(i >= 1 && i <= 9));
         @(negedge clk); start = 1'b0;
      end
      check_drained("t1");

      // Consumer stalls cycles 7..9.
      t = cyc; start = 1'b1; k_len = 4'd3;
      push_feed(t, 3); push_row(t + 10, 0); push_row(t + 11, 1); done_q.push_back(t + 12);
      for (int i = 0; i <= 13; i++) begin
         out_ready = !(i >= 7 && i <= 9);
         if (i >= 7 && i <= 9) begin
            check("t2_stall_valid", out_valid, 1);
            check("t2_stall_row", out_row, 0);
         end
         @(negedge clk); start = 1'b0;
      end
      out_ready = 1'b1;
      check("t2_busy_after", busy, 0);
      check_drained("t2");

      // Zero-length job.
      t = cyc; start = 1'b1; k_len = 4'd0;
      done_q.push_back(t + 1);
      @(negedge clk); start = 1'b0;
      check("t3_busy", busy, 1);
      check("t3_feed_en", feed_en, 0);
      check("t3_acc_clr", acc_clr, 0);
      check("t3_out_valid", out_valid, 0);
      @(negedge clk);
      check_idle("t3_after");

      // Abort at cycle 2, restart at cycle 3.
      t = cyc; start = 1'b1; k_len = 4'd3;
      push_feed(t, 2);
      @(negedge clk); start = 1'b0;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check_idle("t4_abort");
      t = cyc; start = 1'b1; k_len = 4'd3;
      push_k3_job(t);
      repeat (11) begin @(negedge clk); start = 1'b0; end
      check("t4_busy_after", busy, 0);
      check_drained("t4");

      // Start pulses at cycles 2 and 9 (DONE) ignored; k_len changes ignored.
      t = cyc; start = 1'b1; k_len = 4'd3;
      push_k3_job(t);
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         start = (i == 2 || i == 9);
         k_len = 4'd7;
         if (i >= 10) check("t5_busy_idle", busy, 0);
      end
      start = 1'b0;
      check_drained("t5");

      // Synchronous reset mid-job at cycle 5.
      t = cyc; start = 1'b1; k_len = 4'd3;
      push_feed(t, 3);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk); start = 1'b0;
         rst = (i == 5);
         if (i == 6) check_idle("t5_rst");
      end
      rst = 1'b0;
      @(negedge clk);
      check_drained("t5_rst");

      // Abort and start together in IDLE: start dropped.
      start = 1'b1; abort = 1'b1; k_len = 4'd3;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      check("t6_busy", busy, 0);
      check("t6_feed_en", feed_en, 0);
      @(negedge clk);
      check("t6_busy_later", busy, 0);

      // Maximum k_len = 2^KW-1 feeds every index without wrap.
      t = cyc; start = 1'b1; k_len = 4'd15;
      push_feed(t, 15); push_row(t + 19, 0); push_row(t + 20, 1); done_q.push_back(t + 21);
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk); start = 1'b0;
         if (i == 21) check("t7_busy_done", busy, 1);
         if (i == 22) check("t7_busy_after", busy, 0);
      end
      @(negedge clk);
      check_drained("t7");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Sequences one matrix-tile job through the ROWS x COLS systolic PE array. For each job it:
- generates the operand-buffer read index and a per-row skewed feed-enable mask for the array's left and top edges,
- waits out the pipeline drain,
- streams the result rows out under a valid/ready handshake.

It sits between the host/job queue and the PE array plus its A/B operand buffers and result buffer.

## Interface
Parameters
- ROWS, 2, PE rows in the array (≥1)
- COLS, 2, PE columns in the array (≥1)
- KW, 8, width of the inner-dimension length `k_len`
- Derived: RW = max(1, clog2(ROWS)); DRAIN = ROWS + COLS - 1

Ports
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  job request, sampled only in IDLE
- k_len  in  KW  inner-dimension steps for the job, sampled with start
- abort  in  1  synchronous job cancel
- busy  out  1  high from the cycle after start acceptance through the DONE cycle
- done  out  1  one-cycle completion pulse
- acc_clr  out  1  clear PE accumulators/partial sums; high in the first feed cycle only
- feed_en  out  1  operand at feed_addr is presented to the array this cycle
- feed_addr  out  KW  operand-buffer index k
- row_en  out  ROWS  skewed valid mask; row_en[0] = feed_en, row_en[r] = row_en[r-1] delayed 1 cycle
- out_valid  out  1  result row available
- out_ready  in  1  consumer accepts the result row
- out_row  out  RW  index of the result row offered

## Operation
States are IDLE, LOAD, DRAIN, WRITE and DONE.

- **IDLE**
  - start=1 and k_len≠0: latch k_len and go to LOAD.
  - start=1 and k_len=0: go directly to DONE. No feed, no write.
- **LOAD**
  - feed_en=1 and feed_addr counts 0..k_len-1, one per cycle.
  - acc_clr=1 only while feed_addr=0.
  - After feed_addr=k_len-1, go to DRAIN with the drain counter at 0.
- **DRAIN**
  - feed_en=0. The row_en shift register continues shifting out.
  - Count DRAIN cycles, then go to WRITE.
- **WRITE**
  - out_valid=1 and out_row starts at 0.
  - out_row advances only on out_valid & out_ready.
  - The handshake at out_row=ROWS-1 moves the FSM to DONE.
  - out_ready low stalls indefinitely with out_row held.
- **DONE**
  - done=1 and busy=1 for exactly one cycle, then IDLE.

Boundary conditions:
- start outside IDLE, including the DONE cycle, is ignored and never queued.
- k_len changes after acceptance have no effect.
- abort in any non-IDLE state:
  - next cycle is IDLE,
  - all outputs return to reset values, with row_en cleared entirely,
  - no done pulse.
- abort in IDLE has no effect.
- abort and start in the same IDLE cycle: abort wins and the start is dropped.
- rst has priority over everything. It takes effect the cycle after assertion, including mid-job, and behaves like abort.
- k_len = 2^KW-1 must feed every index without feed_addr wrapping.

## Timing
- Reset values: every output is 0, the state is IDLE and the counters are 0.
- All outputs are registered. No combinational path from inputs to outputs, except that out_valid is not gated by out_ready.
- For a job accepted at cycle T with k_len=K:
  - feed cycles are T+1..T+K,
  - row_en[r] is high during T+1+r..T+K+r,
  - drain cycles are T+K+1..T+K+DRAIN,
  - the first out_valid is at T+K+DRAIN+1.
- With out_ready held high:
  - the last row is accepted at T+K+DRAIN+ROWS,
  - done is at T+K+DRAIN+ROWS+1,
  - busy is low at T+K+DRAIN+ROWS+2,
  - the earliest next start is accepted in that same cycle.
- k_len=0: done at T+1, busy at T+1 only.

## Test plan
- ROWS=COLS=2, reset, then start at cycle 0 with k_len=3 and out_ready=1 → response as follows:
  - feed_addr 0,1,2 at cycles 1–3, acc_clr at cycle 1 only,
  - row_en[1] high at cycles 2–4,
  - out_row 0 at cycle 7 and 1 at cycle 8,
  - done at cycle 9, busy=0 at cycle 10.
- Same job with out_ready low at cycles 7–9 → out_valid held with out_row=0 through cycle 9; row 0 accepted at 10, row 1 at 11, done at 12.
- start with k_len=0 → done and busy at cycle 1 only; feed_en, acc_clr and out_valid never assert.
- abort at cycle 2 of a k_len=3 job → cycle 3 has busy=0, feed_en=0, row_en=0, no done; a new start at cycle 3 is accepted normally.
- start pulses at cycles 2 and 9 (DONE cycle) of a k_len=3 job → both ignored, exactly one done pulse; rst at cycle 5 → all outputs 0 at cycle 6.
- KW=4 with k_len=15 → feed_addr runs 0..15-1 with no wrap, 15 feed cycles, done at cycle 15+3+2+1=21.
